// File: rtl/ft6_pkg.sv
// Shared types and constants for the FT60x stream writer.
package ft6_pkg;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } ft6_state_e;

  // Sequence counter and packet word counter widths.
  localparam int FT6_SEQ_W = 16;
  localparam int FT6_CNT_W = 16;

  // Default magic value; narrower buses keep its low bits.
  localparam logic [14:0] FT6_HDR_MAGIC_DEF = 15'h2A5A;

  // Header layout: {ovf (MSB), magic, seq[DATA_W/2-1:0] (LSBs)}.
  function automatic int ft6_magic_w(input int data_w);
    return data_w / 2 - 1;
  endfunction

  function automatic int ft6_seq_field_w(input int data_w);
    return data_w / 2;
  endfunction

  // The FT60x bus only exists in 16- and 32-bit flavours.
  function automatic bit ft6_width_ok(input int data_w);
    return (data_w == 16) || (data_w == 32);
  endfunction

endpackage

// File: rtl/ft6_skid_buf.sv
// Two-entry ordered buffer: a registered output stage plus one skid register.
module ft6_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic [1:0]   o_occ
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         w_pop;

  // A pop only means something when the output stage holds a word.
  assign w_pop = i_pop & r_out_valid;

  // Advance the skid word into the output stage on pop; new words fill the oldest free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= i_push;
        if (i_push) r_skid_data <= i_push_data;
      end else begin
        r_out_valid <= i_push;
        if (i_push) r_out_data <= i_push_data;
      end
    end else if (i_push) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_push_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= i_push_data;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_occ       = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/ft6_stream_writer.sv
// Drains the sample FIFO onto the FT60x synchronous write bus, optionally
// framing every PKT_WORDS data words with a header word.
module ft6_stream_writer
  import ft6_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PKT_WORDS = 1024,
  parameter bit HDR_EN    = 1'b1,
  parameter logic [ft6_magic_w(DATA_W)-1:0] HDR_MAGIC =
    FT6_HDR_MAGIC_DEF[ft6_magic_w(DATA_W)-1:0]
) (
  input  logic                  ft6_clk,
  input  logic                  rst_n,
  input  logic                  stream_en,
  input  logic                  ovf_in,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  ft6_txe_n,
  output logic [DATA_W-1:0]     ft6_data,
  output logic [DATA_W/8-1:0]   ft6_be,
  output logic                  ft6_wr_n,
  output logic                  busy,
  output logic [FT6_SEQ_W-1:0]  seq_num
);

  localparam int SEQ_FW = ft6_seq_field_w(DATA_W);
  localparam logic [FT6_CNT_W-1:0] PKT_LOAD = 16'(PKT_WORDS);

  if (!ft6_width_ok(DATA_W)) begin : g_bad_width
    $error("ft6_stream_writer: DATA_W must be 16 or 32");
  end

  ft6_state_e            r_state, w_state_next;
  logic [FT6_CNT_W-1:0]  r_reads_left, w_reads_left_next;
  logic [FT6_SEQ_W-1:0]  r_seq, w_seq_next;
  logic                  r_ovf;
  logic                  r_inflight;

  logic                  w_out_valid;
  logic [DATA_W-1:0]     w_out_data;
  logic [1:0]            w_occ;
  logic                  w_accept;
  logic [2:0]            w_level;
  logic                  w_room;
  logic                  w_hdr_push;
  logic                  w_rd;
  logic                  w_push;
  logic [DATA_W-1:0]     w_push_data;
  logic [DATA_W-1:0]     w_hdr_word;

  // The host takes the output word on any edge where it is valid and TXE is low.
  assign w_accept = w_out_valid & ~ft6_txe_n;

  // Words held or on their way, minus the one leaving now, must leave a free slot.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_room  = (w_level <= (3'd1 + {2'b00, w_accept}));

  assign w_hdr_word = {r_ovf, HDR_MAGIC, r_seq[SEQ_FW-1:0]};

  // A header is only enqueued with no read in flight, so the two sources never collide.
  assign w_push      = r_inflight | w_hdr_push;
  assign w_push_data = r_inflight ? fifo_data : w_hdr_word;

  ft6_skid_buf #(
    .W (DATA_W)
  ) u_skid (
    .clk         (ft6_clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_accept),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .o_occ       (w_occ)
  );

  // Next-state, read issue and header enqueue decisions.
  always_comb begin
    w_state_next      = r_state;
    w_reads_left_next = r_reads_left;
    w_seq_next        = r_seq;
    w_hdr_push        = 1'b0;
    w_rd              = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (stream_en && !fifo_empty) begin
          w_state_next      = HDR_EN ? S_HDR : S_DATA;
          w_reads_left_next = PKT_LOAD;
        end
      end
      S_HDR: begin
        if (!r_inflight && w_room) begin
          w_hdr_push   = 1'b1;
          w_seq_next   = r_seq + 16'd1;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (!fifo_empty && (r_reads_left != '0) && w_room) begin
          w_rd = 1'b1;
          if (r_reads_left == 16'd1) begin
            // Packet boundary: stream_en is only looked at here.
            w_reads_left_next = PKT_LOAD;
            if (stream_en) w_state_next = HDR_EN ? S_HDR : S_DATA;
            else           w_state_next = S_IDLE;
          end else begin
            w_reads_left_next = r_reads_left - 16'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counters, read-in-flight marker and sticky overflow flag.
  always_ff @(posedge ft6_clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_reads_left <= '0;
      r_seq        <= '0;
      r_ovf        <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_reads_left <= w_reads_left_next;
      r_seq        <= w_seq_next;
      // A new overflow wins over the clear so it lands in the next header.
      r_ovf        <= ovf_in | (r_ovf & ~w_hdr_push);
      r_inflight   <= w_rd;
    end
  end

  assign fifo_rd_en = w_rd;
  assign ft6_wr_n   = ~w_out_valid;
  assign ft6_data   = w_out_data;
  assign ft6_be     = {(DATA_W/8){w_out_valid}};
  assign busy       = (r_state != S_IDLE) | (w_occ != 2'd0) | r_inflight;
  assign seq_num    = r_seq;

endmodule

// File: tb/tb_ft6_stream_writer.sv
// Directed bench: a 32-bit framed instance (4-word packets) and a 16-bit raw instance.
module tb_ft6_stream_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit, framed instance
  logic        a_stream_en, a_ovf_in, a_fifo_empty, a_fifo_rd_en, a_txe_n;
  logic [31:0] a_fifo_data, a_data;
  logic [3:0]  a_be;
  logic        a_wr_n, a_busy;
  logic [15:0] a_seq;

  // 16-bit, raw instance
  logic        b_stream_en, b_ovf_in, b_fifo_empty, b_fifo_rd_en, b_txe_n;
  logic [15:0] b_fifo_data, b_data;
  logic [1:0]  b_be;
  logic        b_wr_n, b_busy;
  logic [15:0] b_seq;

  ft6_stream_writer #(.DATA_W(32), .PKT_WORDS(4), .HDR_EN(1'b1)) dut_a (
    .ft6_clk(clk), .rst_n(rst_n), .stream_en(a_stream_en), .ovf_in(a_ovf_in),
    .fifo_empty(a_fifo_empty), .fifo_data(a_fifo_data), .fifo_rd_en(a_fifo_rd_en),
    .ft6_txe_n(a_txe_n), .ft6_data(a_data), .ft6_be(a_be), .ft6_wr_n(a_wr_n),
    .busy(a_busy), .seq_num(a_seq)
  );

  ft6_stream_writer #(.DATA_W(16), .PKT_WORDS(2), .HDR_EN(1'b0)) dut_b (
    .ft6_clk(clk), .rst_n(rst_n), .stream_en(b_stream_en), .ovf_in(b_ovf_in),
    .fifo_empty(b_fifo_empty), .fifo_data(b_fifo_data), .fifo_rd_en(b_fifo_rd_en),
    .ft6_txe_n(b_txe_n), .ft6_data(b_data), .ft6_be(b_be), .ft6_wr_n(b_wr_n),
    .busy(b_busy), .seq_num(b_seq)
  );

  // Non-FWFT FIFO models: data appears the cycle after the read strobe.
  logic [31:0] a_mem [0:63];
  int          a_wr_ptr = 0;
  int          a_rd_ptr = 0;
  logic [15:0] b_mem [0:7];
  int          b_wr_ptr = 0;
  int          b_rd_ptr = 0;

  assign a_fifo_empty = (a_wr_ptr == a_rd_ptr);
  assign b_fifo_empty = (b_wr_ptr == b_rd_ptr);

  always @(posedge clk) begin
    if (a_fifo_rd_en) begin
      a_fifo_data <= a_mem[a_rd_ptr[5:0]];
      a_rd_ptr    <= a_rd_ptr + 1;
    end
    if (b_fifo_rd_en) begin
      b_fifo_data <= b_mem[b_rd_ptr[2:0]];
      b_rd_ptr    <= b_rd_ptr + 1;
    end
  end

  task automatic push_a(input logic [31:0] w);
    a_mem[a_wr_ptr[5:0]] = w;
    a_wr_ptr = a_wr_ptr + 1;
  endtask

  task automatic push_b(input logic [15:0] w);
    b_mem[b_wr_ptr[2:0]] = w;
    b_wr_ptr = b_wr_ptr + 1;
  endtask

  // Bus monitors: log every word the host accepts.
  int          cyc = 0;
  logic [31:0] a_log [$];
  int          a_log_cyc [$];
  logic [15:0] b_log [$];
  logic [1:0]  b_log_be [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!a_wr_n && !a_txe_n) begin
      a_log.push_back(a_data);
      a_log_cyc.push_back(cyc);
      $display("A word #%0d cyc %0d data %h be %h", a_log.size() - 1, cyc, a_data, a_be);
    end
    if (!b_wr_n && !b_txe_n) begin
      b_log.push_back(b_data);
      b_log_be.push_back(b_be);
      $display("B word #%0d cyc %0d data %h be %b", b_log.size() - 1, cyc, b_data, b_be);
    end
  end

  // Words read from the FIFO but not yet taken by the host (headers excluded).
  logic a_acc_data;
  int   a_outst = 0;
  int   a_outst_max = 0;
  assign a_acc_data = !a_wr_n && !a_txe_n && (a_data[30:16] != 15'h2A5A);

  always @(posedge clk) begin
    if (!rst_n) begin
      a_outst <= 0;
    end else begin
      a_outst <= a_outst + (a_fifo_rd_en ? 1 : 0) - (a_acc_data ? 1 : 0);
      if (a_outst + (a_fifo_rd_en ? 1 : 0) - (a_acc_data ? 1 : 0) > a_outst_max)
        a_outst_max <= a_outst + (a_fifo_rd_en ? 1 : 0) - (a_acc_data ? 1 : 0);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (a_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (a_log.size() >= n)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d words, expected %0d", tag, a_log.size(), n);
    end
  endtask

  // Hand-derived bus sequence for the whole run of instance A.
  logic [31:0] exp_a [0:34] = '{
    32'h2A5A0000, 32'd0, 32'd1, 32'd2, 32'd3,
    32'h2A5A0001, 32'd4, 32'd5, 32'd6, 32'd7,
    32'h2A5A0002, 32'd8, 32'd9, 32'd10, 32'd11,
    32'hAA5A0003, 32'd12, 32'd13, 32'd14, 32'd15,
    32'h2A5A0004, 32'd16, 32'd17, 32'd18, 32'd19,
    32'h2A5A0005, 32'd20, 32'd21, 32'd22, 32'd23,
    32'hAA5A0006, 32'd24, 32'd25,
    32'h2A5A0000, 32'd28
  };
  int gap_idx [0:6] = '{1, 2, 3, 4, 6, 7, 8};

  initial begin
    rst_n = 1'b0;
    a_stream_en = 1'b1; a_ovf_in = 1'b0; a_txe_n = 1'b0;
    b_stream_en = 1'b1; b_ovf_in = 1'b0; b_txe_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_n", 32'(a_wr_n), 32'd1);
    chk("rst_be", 32'(a_be), 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_rd_en", 32'(a_fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_seq", 32'(a_seq), 32'd0);
    chk("rst_b_wr_n", 32'(b_wr_n), 32'd1);

    // Two packets plus the next header; raw 16-bit stream in parallel
    for (int i = 0; i < 8; i++) push_a(32'(i));
    push_b(16'hAAAA);
    push_b(16'hBBBB);
    rst_n = 1'b1;
    wait_a(11, 80, "pkt01_words");
    chk("b_count", 32'(b_log.size()), 32'd2);
    chk("b_word0", (b_log.size() > 0) ? 32'(b_log[0]) : 32'hxxxxxxxx, 32'h0000AAAA);
    chk("b_word1", (b_log.size() > 1) ? 32'(b_log[1]) : 32'hxxxxxxxx, 32'h0000BBBB);
    chk("b_be", (b_log_be.size() > 0) ? 32'(b_log_be[0]) : 32'hxxxxxxxx, 32'd3);
    chk("b_seq", 32'(b_seq), 32'd0);

    // TXE stall for three cycles mid-packet plus an overflow pulse
    for (int i = 8; i < 16; i++) push_a(32'(i));
    wait_a(13, 40, "pre_stall");
    a_txe_n = 1'b1;
    a_ovf_in = 1'b1;
    @(negedge clk);
    a_ovf_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wr_n", 32'(a_wr_n), 32'd0);
      chk("stall_data", a_data, 32'd10);
      if (i < 2) @(negedge clk);
    end
    a_txe_n = 1'b0;
    wait_a(21, 60, "pkt23_words");

    // Header blocked on a full buffer; overflow pulse in its enqueue cycle
    push_a(32'd16);
    push_a(32'd17);
    wait_a(23, 40, "w17");
    a_txe_n = 1'b1;
    push_a(32'd18);
    push_a(32'd19);
    repeat (3) @(negedge clk);
    chk("full_wr_n", 32'(a_wr_n), 32'd0);
    chk("full_data", a_data, 32'd18);
    @(negedge clk);
    chk("full_data2", a_data, 32'd18);
    a_txe_n = 1'b0;
    a_ovf_in = 1'b1;
    @(negedge clk);
    a_ovf_in = 1'b0;

    // stream_en dropped after the 2nd data word: packet completes, then idle
    push_a(32'd20);
    push_a(32'd21);
    wait_a(28, 40, "w21");
    a_stream_en = 1'b0;
    push_a(32'd22);
    push_a(32'd23);
    wait_a(30, 40, "w23");
    @(negedge clk);
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_seq", 32'(a_seq), 32'd6);
    push_a(32'd24);
    push_a(32'd25);
    for (int i = 0; i < 6; i++) begin
      chk("idle_rd_en", 32'(a_fifo_rd_en), 32'd0);
      @(negedge clk);
    end
    a_stream_en = 1'b1;
    wait_a(33, 40, "hdr6_words");

    // Reset with a full buffer, then restart
    a_txe_n = 1'b1;
    push_a(32'd26);
    push_a(32'd27);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(a_busy), 32'd1);
    chk("pre_rst_data", a_data, 32'd26);
    chk("pre_rst_be", 32'(a_be), 32'hF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_n", 32'(a_wr_n), 32'd1);
    chk("mid_rst_be", 32'(a_be), 32'd0);
    chk("mid_rst_data", a_data, 32'd0);
    chk("mid_rst_seq", 32'(a_seq), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_rd_en", 32'(a_fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    a_txe_n = 1'b0;
    push_a(32'd28);
    wait_a(35, 40, "restart_words");
    repeat (3) @(negedge clk);
    chk("restart_seq", 32'(a_seq), 32'd1);

    // Whole bus sequence, in order, no loss or duplicates
    chk("a_count", 32'(a_log.size()), 32'd35);
    for (int i = 0; i < 35; i++)
      chk($sformatf("a_word%0d", i), (i < a_log.size()) ? a_log[i] : 32'hxxxxxxxx, exp_a[i]);
    for (int i = 0; i < 7; i++)
      chk($sformatf("gapless%0d", gap_idx[i]),
          (a_log_cyc.size() > gap_idx[i] + 1) ?
            32'(a_log_cyc[gap_idx[i] + 1] - a_log_cyc[gap_idx[i]]) : 32'hxxxxxxxx,
          32'd1);
    chk("max_outstanding_le2", 32'(a_outst_max <= 2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Backstop in case a wait loop logic error lets the run stall.
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: observed no finish, expected finish within 5000 cycles");
    $fatal(1);
  end

endmodule
